// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : serial receiver feeding the boot loader.
//
// Deserialises the asynchronous `rx` line (8N1, LSB first) into bytes and
// reports each byte with a single ce-cycle strobe. The whole block runs on the
// CPU clock and freezes while `ce` is low.
//
// Optional build macro: UART_RX_PARITY_EN
//   undefined : 8N1 frames; parity_err is constant 0.
//   defined   : 8E1 frames; a bad even-parity bit raises parity_err instead
//               of data_valid (data_out is still updated).
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active-high, priority over ce
//   ce         : clock enable, no register updates while 0
//   rx         : asynchronous serial input, idle high
//   data_out   : last byte received with a good stop bit
//   data_valid : one ce-cycle strobe when data_out is updated
//   frame_err  : one ce-cycle strobe when the stop bit is sampled as 0
//   parity_err : one ce-cycle strobe on an even-parity mismatch
//   busy       : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_WIDTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // Start bit is re-checked at its midpoint, data/stop bits one period apart.
    localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(CLKS_PER_BIT / 32'sd2 - 32'sd1);
    localparam logic [CNT_WIDTH-1:0] FULL_LAST = CNT_WIDTH'(CLKS_PER_BIT - 32'sd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd5,
`endif
        ST_WAIT_HIGH = 3'd4
    } state_t;

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [2:0]           bit_idx_r;
    logic [7:0]           shift_r;
    logic                 cnt_half_s;
    logic                 cnt_full_s;
    logic                 parity_bad_s;
    logic                 load_s;
    logic                 valid_next_s;
    logic                 ferr_next_s;
    logic                 perr_next_s;
    logic [7:0]           data_out_r;
    logic                 data_valid_r;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 busy_r;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_r;
`endif

    // Even parity over the eight data bits plus the received parity bit.
    function automatic logic even_parity_bad(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    assign cnt_half_s = (cnt_r == HALF_LAST);
    assign cnt_full_s = (cnt_r == FULL_LAST);

`ifdef UART_RX_PARITY_EN
    assign parity_bad_s = even_parity_bad(shift_r, parity_bit_r);
`else
    assign parity_bad_s = 1'b0;
`endif

    // Two-flop synchroniser; both flops reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else if (ce) begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (ce) begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!rx_sync_r) state_next_s = ST_START;
                else            state_next_s = ST_IDLE;
            end
            ST_START: begin
                // A line that is high again at mid-start-bit was only a glitch.
                if (cnt_half_s) state_next_s = rx_sync_r ? ST_IDLE : ST_DATA;
                else            state_next_s = ST_START;
            end
            ST_DATA: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_full_s && (bit_idx_r == 3'd7)) state_next_s = ST_PARITY;
`else
                if (cnt_full_s && (bit_idx_r == 3'd7)) state_next_s = ST_STOP;
`endif
                else                                   state_next_s = ST_DATA;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_full_s) state_next_s = ST_STOP;
                else            state_next_s = ST_PARITY;
            end
`endif
            ST_STOP: begin
                // A low stop bit may be a break; hold off until the line idles.
                if (cnt_full_s) state_next_s = rx_sync_r ? ST_IDLE : ST_WAIT_HIGH;
                else            state_next_s = ST_STOP;
            end
            ST_WAIT_HIGH: begin
                if (rx_sync_r) state_next_s = ST_IDLE;
                else           state_next_s = ST_WAIT_HIGH;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: decide strobes and data load at the stop-bit sample.
    always_comb begin
        load_s       = 1'b0;
        valid_next_s = 1'b0;
        ferr_next_s  = 1'b0;
        perr_next_s  = 1'b0;
        if ((state_r == ST_STOP) && cnt_full_s) begin
            if (rx_sync_r) begin
                load_s = 1'b1;
                if (parity_bad_s) perr_next_s  = 1'b1;
                else              valid_next_s = 1'b1;
            end else begin
                ferr_next_s = 1'b1;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Bit-period counter, bit index and data shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            parity_bit_r <= 1'b0;
`endif
        end else if (ce) begin
            case (state_r)
                ST_START: begin
                    if (cnt_half_s) begin
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_full_s) begin
                        shift_r[bit_idx_r] <= rx_sync_r;
                        bit_idx_r          <= bit_idx_r + 3'd1;
                        cnt_r              <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_full_s) begin
                        parity_bit_r <= rx_sync_r;
                        cnt_r        <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_full_s) cnt_r <= '0;
                    else            cnt_r <= cnt_r + CNT_ONE;
                end
                default: cnt_r <= '0;
            endcase
        end
    end

    // Registered outputs; strobes last exactly one ce-cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            busy_r       <= 1'b0;
        end else if (ce) begin
            if (load_s) data_out_r <= shift_r;
            data_valid_r <= valid_next_s;
            frame_err_r  <= ferr_next_s;
            parity_err_r <= perr_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign busy       = busy_r;

endmodule
